fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter that shares one synchronous FIFO write port among NREQ producers.
//  A producer holds its grant for a burst, which ends on last, MAX_BURST beats, or req dropped.
//  The block drives the FIFO write/data pins and respects FIFO full, so producers never overflow it.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// the default geometry of the synchronous FIFO the arbiter feeds.
package fifo_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_XFER = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        XFER = ST_XFER
    } arb_state_e;

    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 16;

    // Width of an index able to address n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NREQ, returned as a one-hot vector.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] sel,
    output logic            valid
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NREQ
// producers; a grant lasts until last, MAX_BURST beats, or the owner drops req.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = FIFO_DW,
    parameter int MAX_BURST = 8
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    last,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    gnt,
    input  logic               fifo_full,
    output logic               fifo_write,
    output logic [DW-1:0]      fifo_wdata,
    output logic               busy
);

    localparam int PW = idx_width(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] pick_sel;
    logic            pick_valid;

    logic [PW-1:0]   own_idx;
    logic            own_req;
    logic            own_last;
    logic [DW-1:0]   own_data;
    logic            beat;
    logic            release_now;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    // The owner's lane is selected by the registered one-hot grant.
    always_comb begin
        own_idx  = '0;
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                own_idx  = PW'(i);
                own_req  = req[i];
                own_last = last[i];
                own_data = wdata[i*DW +: DW];
            end
        end
    end

    assign beat        = (state_q == XFER) && own_req && !fifo_full;
    assign release_now = (state_q == XFER) &&
                         (!own_req || (beat && (own_last || cnt_q == CW'(MAX_BURST - 1))));

    assign ack        = beat ? gnt_q : '0;
    assign fifo_write = beat;
    assign fifo_wdata = beat ? own_data : '0;
    assign gnt        = gnt_q;
    assign busy       = (state_q == XFER);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_sel;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (release_now) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = (own_idx == PW'(NREQ - 1)) ? '0 : own_idx + PW'(1);
                    state_d = IDLE;
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    a_gnt_onehot : assert property (@(posedge CLK) disable iff (!RSTn) $onehot0(gnt_q));
    a_no_ovf     : assert property (@(posedge CLK) disable iff (!RSTn) !(fifo_write && fifo_full));
    a_idle_nognt : assert property (@(posedge CLK) disable iff (!RSTn) (state_q == IDLE) |-> (gnt_q == '0));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a queue-based FIFO and producers.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int MAXB  = 8;
    localparam int DEPTH = 16;

    logic               CLK = 1'b0;
    logic               RSTn = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    last = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    gnt;
    logic               fifo_full = 1'b0;
    logic               fifo_write;
    logic [DW-1:0]      fifo_wdata;
    logic               busy;

    always #5 CLK = ~CLK;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAXB)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .req        (req),
        .last       (last),
        .wdata      (wdata),
        .ack        (ack),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic [NREQ-1:0] ack;
    } ctl_t;

    logic [8:0]      src_q [NREQ][$];
    logic [7:0]      fifo_q[$];
    ctl_t            ctl_q[$];
    logic [7:0]      wr_q[$];

    logic            rst_val = 1'b1;
    logic            rd_en = 1'b0;
    logic [NREQ-1:0] hold = '0;
    logic [NREQ-1:0] ack_s = '0;
    logic            wr_s = 1'b0;
    logic [7:0]      wd_s = '0;
    logic            rd_s = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int wr_total = 0;
    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input int n, input logic [7:0] base, input bit last_end);
        for (int k = 0; k < n; k++)
            src_q[i].push_back({(last_end && k == n - 1), 8'(base + 8'(k))});
    endtask

    // Reference: one cycle of the arbitration rules, evaluated on the driven inputs.
    task automatic model_step();
        ctl_t c;
        bit   found;
        bit   bt;
        int   g;
        c.gnt  = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
        c.busy = (m_owner >= 0);
        c.ack  = '0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    found = 1;
                end
            end
        end else begin
            g  = m_owner;
            bt = req[g] && !fifo_full;
            if (bt) begin
                c.ack = NREQ'(1 << g);
                wr_q.push_back(wdata[g*DW +: DW]);
                m_cnt++;
            end
            if (!req[g] || (bt && (last[g] || m_cnt == MAXB))) begin
                m_ptr   = (g + 1) % NREQ;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        ctl_q.push_back(c);
    endtask

    task automatic cycle();
        logic [8:0] h;
        @(negedge CLK);
        if (RSTn) begin
            for (int i = 0; i < NREQ; i++)
                if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (wr_s) begin
                fifo_q.push_back(wd_s);
                wr_total++;
            end
        end
        RSTn = rst_val;
        if (!RSTn) fifo_q.delete();
        fifo_full = (fifo_q.size() == DEPTH);
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                req[i] = !hold[i];
                last[i] = h[8];
                wdata[i*DW +: DW] = h[7:0];
            end else begin
                req[i] = 1'b0;
                last[i] = 1'b0;
                wdata[i*DW +: DW] = '0;
            end
        end
        if (RSTn) model_step();
        else begin
            m_owner = -1;
            m_ptr = 0;
            m_cnt = 0;
        end
        #2;
        ack_s = ack;
        wr_s  = fifo_write;
        wd_s  = fifo_wdata;
        rd_s  = rd_en;
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        repeat (n) cycle();
        rd_en = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_write"}, 32'(fifo_write), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wdata"}, 32'(fifo_wdata), 0);
    endtask

    // Monitor: compares DUT outputs with the queued expectations each cycle.
    initial begin
        ctl_t c;
        forever begin
            @(negedge CLK);
            #2;
            if (ctl_q.size() > 0) begin
                c = ctl_q.pop_front();
                chk("gnt", 32'(gnt), 32'(c.gnt));
                chk("busy", 32'(busy), 32'(c.busy));
                chk("ack", 32'(ack), 32'(c.ack));
                chk("write_while_full", 32'(fifo_write && fifo_full), 0);
                if (fifo_write) begin
                    if (wr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got data %0h expected no write", fifo_wdata);
                    end else begin
                        chk("wdata", 32'(fifo_wdata), 32'(wr_q.pop_front()));
                    end
                end else begin
                    chk("idle_wdata", 32'(fifo_wdata), 0);
                end
            end
        end
    end

    initial begin
        int w0;
        // Reset held with every requester asking.
        for (int r = 0; r < NREQ; r++) load(r, 2, 8'(r << 4), 1'b1);
        rst_val = 1'b0;
        repeat (3) cycle();
        chk_outputs_zero("reset");
        rst_val = 1'b1;
        cycle();
        chk("first_gnt_decision", 32'(gnt), 0);
        cycle();
        chk("first_gnt", 32'(gnt), 32'h1);

        // Round-robin, two beats per burst.
        repeat (14) cycle();
        chk("rr_count", 32'(fifo_q.size()), 8);
        if (fifo_q.size() == 8)
            for (int j = 0; j < 8; j++)
                chk("rr_order", 32'(fifo_q[j]), 32'(((j / 2) << 4) | (j % 2)));
        drain(20);

        // Burst cap on a lone requester without last.
        load(2, 12, 8'h20, 1'b0);
        repeat (30) cycle();
        chk("cap_count", 32'(fifo_q.size()), 12);
        if (fifo_q.size() == 12)
            for (int j = 0; j < 12; j++)
                chk("cap_data", 32'(fifo_q[j]), 32'(8'h20 + j));
        drain(20);

        // Full stall with no reads, then a single read.
        w0 = wr_total;
        load(1, 20, 8'h40, 1'b1);
        repeat (30) cycle();
        chk("stall_writes", 32'(wr_total - w0), 16);
        chk("stall_full", 32'(fifo_full), 1);
        chk("stall_gnt", 32'(gnt), 32'h2);
        chk("stall_ack", 32'(ack), 0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        repeat (6) cycle();
        chk("one_more_beat", 32'(wr_total - w0), 17);
        chk("refull", 32'(fifo_q.size()), 16);
        drain(30);
        chk("stall_total", 32'(wr_total - w0), 20);

        // Abandon by requester 3, then 0 ahead of 1.
        load(3, 3, 8'h60, 1'b0);
        cycle();
        load(0, 2, 8'h50, 1'b1);
        load(1, 1, 8'h70, 1'b1);
        repeat (14) cycle();
        chk("abandon_count", 32'(fifo_q.size()), 6);
        if (fifo_q.size() == 6) begin
            chk("abandon_d0", 32'(fifo_q[2]), 32'h62);
            chk("abandon_next0", 32'(fifo_q[3]), 32'h50);
            chk("abandon_next1", 32'(fifo_q[4]), 32'h51);
            chk("abandon_then1", 32'(fifo_q[5]), 32'h70);
        end
        drain(20);

        // Reset pulsed during the second beat of a burst.
        load(2, 6, 8'h80, 1'b1);
        cycle();
        cycle();
        rst_val = 1'b0;
        cycle();
        chk_outputs_zero("midreset");
        rst_val = 1'b1;
        repeat (12) cycle();
        chk("midreset_count", 32'(fifo_q.size()), 5);
        if (fifo_q.size() == 5)
            for (int j = 0; j < 5; j++)
                chk("midreset_data", 32'(fifo_q[j]), 32'(8'h81 + j));
        drain(20);

        // Randomized traffic, holds and reader stalls.
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                int i;
                i = int'($urandom_range(0, NREQ - 1));
                if (src_q[i].size() < 20)
                    load(i, int'($urandom_range(1, 12)), 8'($urandom_range(0, 255)),
                         $urandom_range(0, 3) != 0);
            end
            for (int i = 0; i < NREQ; i++) hold[i] = ($urandom_range(0, 19) == 0);
            if (t % 200 < 40) rd_en = 1'b0;
            else rd_en = ($urandom_range(0, 2) != 0);
            cycle();
        end
        hold = '0;
        drain(400);
        chk("scoreboard_empty", 32'(wr_q.size()), 0);
        for (int i = 0; i < NREQ; i++) chk("src_empty", 32'(src_q[i].size()), 0);
        @(negedge CLK);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
